// File: rtl/msrv32_wb_scoreboard.sv
// msrv32_wb_scoreboard: shares the register-file write port between stage-3 and late completions, and stalls decode on outstanding writes.
module msrv32_wb_scoreboard #(
    parameter int MAX_PENDING  = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [4:0]  rs_1_addr_in,
    input  logic [4:0]  rs_2_addr_in,
    input  logic [4:0]  dec_rd_addr_in,
    input  logic        issue_valid_in,
    input  logic [4:0]  issue_rd_in,
    output logic        stall_out,
    input  logic        pipe_wr_en_in,
    input  logic [4:0]  pipe_rd_addr_in,
    input  logic [31:0] pipe_rd_in,
    output logic        pipe_hold_out,
    input  logic        late_valid_in,
    input  logic [4:0]  late_rd_addr_in,
    input  logic [31:0] late_rd_in,
    output logic        late_ready_out,
    output logic        rf_wr_en_out,
    output logic [4:0]  rf_rd_addr_out,
    output logic [31:0] rf_rd_out
);
    typedef enum logic {ARB, HOLD} state_t;
    state_t      state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic [3:0]  cnt_q, cnt_d, wcnt_q, wcnt_d;
    logic        hold, pipe_req, late_hs, late_sel, pipe_sel, issue_acc;
    always_comb begin
        hold = state_q == HOLD;
        pipe_req = pipe_wr_en_in && pipe_rd_addr_in != 5'd0;
        late_ready_out = hold || !pipe_req;
        late_hs = late_valid_in && late_ready_out;
        late_sel = late_hs && late_rd_addr_in != 5'd0;
        pipe_sel = !late_hs && !hold && pipe_req;
        rf_wr_en_out = late_sel || pipe_sel;
        rf_rd_addr_out = late_sel ? late_rd_addr_in : pipe_sel ? pipe_rd_addr_in : 5'd0;
        rf_rd_out = late_sel ? late_rd_in : pipe_sel ? pipe_rd_in : 32'd0;
        // Hazards look only at registered pending bits; a same-cycle completion does not bypass.
        stall_out = (rs_1_addr_in != 5'd0 && pending_q[rs_1_addr_in])
                 || (rs_2_addr_in != 5'd0 && pending_q[rs_2_addr_in])
                 || (dec_rd_addr_in != 5'd0 && pending_q[dec_rd_addr_in])
                 || (issue_valid_in && cnt_q == 4'(MAX_PENDING))
                 || hold;
        issue_acc = issue_valid_in && !stall_out && issue_rd_in != 5'd0;
        pending_d = (pending_q & ~({31'd0, late_hs} << late_rd_addr_in)) | ({31'd0, issue_acc} << issue_rd_in);
        cnt_d = issue_acc == late_hs ? cnt_q
              : issue_acc ? cnt_q + 4'd1
              : cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
        wcnt_d = (late_valid_in && !late_ready_out)
               ? (wcnt_q == 4'(STARVE_LIMIT) ? wcnt_q : wcnt_q + 4'd1) : 4'd0;
        state_d = hold ? ((late_hs || !late_valid_in) ? ARB : HOLD)
                : (wcnt_d == 4'(STARVE_LIMIT) ? HOLD : ARB);
    end
    assign pipe_hold_out = hold;
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q   <= ARB;
            pending_q <= 32'd0;
            cnt_q     <= 4'd0;
            wcnt_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            wcnt_q    <= wcnt_d;
        end
    end
endmodule

// File: tb/tb_msrv32_wb_scoreboard.sv
// tb_msrv32_wb_scoreboard: directed stimulus checked by a register-level model every cycle plus literal expectations.
module tb_msrv32_wb_scoreboard;
    localparam int MAXP = 4;
    localparam int LIM  = 3;
    logic        clk_in = 1'b0, reset_in = 1'b1;
    logic [4:0]  rs_1_addr_in, rs_2_addr_in, dec_rd_addr_in, issue_rd_in, pipe_rd_addr_in, late_rd_addr_in;
    logic        issue_valid_in, pipe_wr_en_in, late_valid_in;
    logic [31:0] pipe_rd_in, late_rd_in;
    logic        stall_out, pipe_hold_out, late_ready_out, rf_wr_en_out;
    logic [4:0]  rf_rd_addr_out;
    logic [31:0] rf_rd_out;
    int passed = 0, total = 0;

    always #5 clk_in = ~clk_in;

    msrv32_wb_scoreboard #(.MAX_PENDING(MAXP), .STARVE_LIMIT(LIM)) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .rs_1_addr_in(rs_1_addr_in), .rs_2_addr_in(rs_2_addr_in), .dec_rd_addr_in(dec_rd_addr_in),
        .issue_valid_in(issue_valid_in), .issue_rd_in(issue_rd_in), .stall_out(stall_out),
        .pipe_wr_en_in(pipe_wr_en_in), .pipe_rd_addr_in(pipe_rd_addr_in), .pipe_rd_in(pipe_rd_in),
        .pipe_hold_out(pipe_hold_out), .late_valid_in(late_valid_in), .late_rd_addr_in(late_rd_addr_in),
        .late_rd_in(late_rd_in), .late_ready_out(late_ready_out), .rf_wr_en_out(rf_wr_en_out),
        .rf_rd_addr_out(rf_rd_addr_out), .rf_rd_out(rf_rd_out)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // Model: set of registers awaiting completion, outstanding count, refusal streak, hold flag.
    bit m_pend[32];
    int m_cnt, m_wait;
    bit m_hold;

    function automatic bit e_req();
        return pipe_wr_en_in && pipe_rd_addr_in != 0;
    endfunction
    function automatic bit e_ready();
        return m_hold || !e_req();
    endfunction
    function automatic bit e_hs();
        return late_valid_in && e_ready();
    endfunction
    function automatic bit e_late_wr();
        return e_hs() && late_rd_addr_in != 0;
    endfunction
    function automatic bit e_pipe_wr();
        return !m_hold && e_req() && !e_hs();
    endfunction
    function automatic bit e_stall();
        return (rs_1_addr_in != 0 && m_pend[rs_1_addr_in]) || (rs_2_addr_in != 0 && m_pend[rs_2_addr_in])
            || (dec_rd_addr_in != 0 && m_pend[dec_rd_addr_in]) || (issue_valid_in && m_cnt == MAXP) || m_hold;
    endfunction
    function automatic bit e_acc();
        return issue_valid_in && !e_stall() && issue_rd_in != 0;
    endfunction
    function automatic int n_wait();
        if (late_valid_in && !e_hs() && !m_hold) return (m_wait + 1 > LIM) ? LIM : m_wait + 1;
        return 0;
    endfunction

    always @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            m_pend <= '{default: 1'b0};
            m_cnt  <= 0;
            m_wait <= 0;
            m_hold <= 1'b0;
        end else begin
            if (e_hs()) m_pend[late_rd_addr_in] <= 1'b0;
            if (e_acc()) m_pend[issue_rd_in] <= 1'b1;
            if (e_acc() && !e_hs()) m_cnt <= m_cnt + 1;
            else if (e_hs() && !e_acc() && m_cnt > 0) m_cnt <= m_cnt - 1;
            m_wait <= n_wait();
            m_hold <= !m_hold && n_wait() == LIM;
        end
    end

    always @(negedge clk_in) begin
        if (!reset_in) begin
            chk("late_ready", late_ready_out, e_ready());
            chk("rf_wr_en", rf_wr_en_out, e_late_wr() || e_pipe_wr());
            chk("rf_addr", rf_rd_addr_out, e_late_wr() ? late_rd_addr_in : e_pipe_wr() ? pipe_rd_addr_in : 5'd0);
            chk("rf_data", rf_rd_out, e_late_wr() ? late_rd_in : e_pipe_wr() ? pipe_rd_in : 32'd0);
            chk("stall", stall_out, e_stall());
            chk("pipe_hold", pipe_hold_out, m_hold);
        end
    end

    task automatic idle();
        rs_1_addr_in = 0; rs_2_addr_in = 0; dec_rd_addr_in = 0;
        issue_valid_in = 0; issue_rd_in = 0;
        pipe_wr_en_in = 0; pipe_rd_addr_in = 0; pipe_rd_in = 0;
        late_valid_in = 0; late_rd_addr_in = 0; late_rd_in = 0;
    endtask
    task automatic nxt();
        @(posedge clk_in);
        #1;
        idle();
    endtask
    task automatic issue(input logic [4:0] rd);
        issue_valid_in = 1; issue_rd_in = rd;
    endtask
    task automatic pipe(input logic [4:0] a, input logic [31:0] d);
        pipe_wr_en_in = 1; pipe_rd_addr_in = a; pipe_rd_in = d;
    endtask
    task automatic late(input logic [4:0] a, input logic [31:0] d);
        late_valid_in = 1; late_rd_addr_in = a; late_rd_in = d;
    endtask

    initial begin
        int drain[4];
        drain = '{1, 2, 6, 8};
        idle();
        issue_valid_in = 1;
        #12;
        chk("reset_hold", pipe_hold_out, 0);
        chk("reset_stall", stall_out, 0);
        reset_in = 0;
        // RAW on x5 until its completion lands
        nxt(); issue(5); #2; chk("issue5_stall", stall_out, 0);
        nxt(); rs_1_addr_in = 5; #2; chk("raw_stall", stall_out, 1);
        nxt(); rs_1_addr_in = 5; late(5, 32'hDEADBEEF); #2;
        chk("x5_ready", late_ready_out, 1);
        chk("x5_wen", rf_wr_en_out, 1);
        chk("x5_addr", rf_rd_addr_out, 5);
        chk("x5_data", rf_rd_out, 32'hDEADBEEF);
        chk("x5_no_bypass", stall_out, 1);
        nxt(); rs_1_addr_in = 5; issue(7); #2; chk("x5_unstall", stall_out, 0);
        // Pipe beats late
        nxt(); pipe(3, 32'h33); late(7, 32'h77); #2;
        chk("arb_addr", rf_rd_addr_out, 3);
        chk("arb_data", rf_rd_out, 32'h33);
        chk("arb_ready", late_ready_out, 0);
        nxt(); late(7, 32'h77); #2;
        chk("x7_addr", rf_rd_addr_out, 7);
        chk("x7_data", rf_rd_out, 32'h77);
        chk("x7_wen", rf_wr_en_out, 1);
        // Starvation guard
        nxt(); issue(9);
        for (int i = 0; i < LIM; i++) begin
            nxt(); pipe(1, i); late(9, 32'h99); #2;
            chk("starve_ready", late_ready_out, 0);
            chk("starve_hold", pipe_hold_out, 0);
        end
        nxt(); pipe(1, 32'h11); late(9, 32'h99); #2;
        chk("hold_on", pipe_hold_out, 1);
        chk("hold_ready", late_ready_out, 1);
        chk("hold_addr", rf_rd_addr_out, 9);
        chk("hold_stall", stall_out, 1);
        nxt(); pipe(1, 32'h12); #2;
        chk("hold_off", pipe_hold_out, 0);
        chk("hold_off_addr", rf_rd_addr_out, 1);
        // Capacity
        for (int i = 1; i <= 4; i++) begin
            nxt(); issue(5'(i)); #2; chk("fill_stall", stall_out, 0);
        end
        nxt(); issue(6); #2; chk("full_stall", stall_out, 1);
        nxt(); late(4, 32'h44);
        nxt(); issue(6); late(3, 32'h3); #2;
        chk("swap_stall", stall_out, 0);
        chk("swap_addr", rf_rd_addr_out, 3);
        nxt(); issue(8); #2; chk("refill_stall", stall_out, 0);
        nxt(); issue(10); #2; chk("refull_stall", stall_out, 1);
        for (int i = 0; i < 4; i++) begin
            nxt(); late(5'(drain[i]), 32'(drain[i]));
        end
        // x0 handling
        nxt(); pipe(0, 32'h55); #2;
        chk("x0_wen", rf_wr_en_out, 0);
        chk("x0_ready", late_ready_out, 1);
        for (int i = 0; i < 5; i++) begin
            nxt(); issue(0); #2; chk("x0_issue_stall", stall_out, 0);
        end
        // Async reset while holding with pending = x2,x5
        nxt(); issue(2);
        nxt(); issue(5);
        for (int i = 0; i < LIM; i++) begin
            nxt(); pipe(1, 32'h1); late(2, 32'h2);
        end
        nxt(); pipe(1, 32'h1); late(2, 32'h2); rs_1_addr_in = 5; #2;
        chk("pre_rst_hold", pipe_hold_out, 1);
        chk("pre_rst_stall", stall_out, 1);
        reset_in = 1;
        #1;
        chk("rst_hold", pipe_hold_out, 0);
        chk("rst_stall", stall_out, 0);
        #2;
        reset_in = 0;
        nxt(); rs_1_addr_in = 5; rs_2_addr_in = 2; #2;
        chk("post_rst_stall", stall_out, 0);
        nxt();
        @(posedge clk_in);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
